// File: rtl/wave_scheduler.sv
// -----------------------------------------------------------------------------
// wave_scheduler
//
// Game sequencer for a falling-wave dodging game. Up to three "waves"
// (horizontal rows of obstacles, each with a three-column gap) descend the
// board one row per step. A wave leaving the bottom row re-enters at the top
// with a new gap position and scores one point. Every eighth point shortens
// the step period down to a floor.
//
// Optional feature (define the macro to enable):
//   HIGH_SCORE_EN  - keep the best score across games. Without it,
//                    high_score is tied to zero and no compare logic exists.
//
// Parameters
//   BOARD_HEIGHT  rows on the board; waves travel from BOARD_HEIGHT-2 to 1
//   BOARD_WIDTH   columns per wave bitfield (only 40 is supported)
//   BASE_PERIOD   clk cycles per step at game start
//   MIN_PERIOD    floor on the step period
//   PERIOD_STEP   period decrement per speed-up
//   WAVE_GAP      steps between activation of successive waves
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   start       in   one-cycle pulse: begin a game (from IDLE or DEAD)
//   death       in   collision flag from the player logic
//   running     out  high while a game is in progress
//   waveN_y     out  row of wave N (0 when the wave is inactive)
//   waveN_bf    out  occupied columns of wave N (0 when inactive)
//   score       out  current score, saturating at 0xFFFF
//   high_score  out  best score (HIGH_SCORE_EN) or 0
// -----------------------------------------------------------------------------
module wave_scheduler #(
  parameter int BOARD_HEIGHT = 20,
  parameter int BOARD_WIDTH  = 40,
  parameter int BASE_PERIOD  = 50000000,
  parameter int MIN_PERIOD   = 10000000,
  parameter int PERIOD_STEP  = 5000000,
  parameter int WAVE_GAP     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   death,
  output logic                   running,
  output logic [7:0]             wave0_y,
  output logic [7:0]             wave1_y,
  output logic [7:0]             wave2_y,
  output logic [BOARD_WIDTH-1:0] wave0_bf,
  output logic [BOARD_WIDTH-1:0] wave1_bf,
  output logic [BOARD_WIDTH-1:0] wave2_bf,
  output logic [15:0]            score,
  output logic [15:0]            high_score
);

  localparam logic [7:0]  TOP_Y     = 8'(BOARD_HEIGHT - 2);
  localparam logic [31:0] BASE_P    = 32'(BASE_PERIOD);
  localparam logic [31:0] MIN_P     = 32'(MIN_PERIOD);
  localparam logic [31:0] STEP_P    = 32'(PERIOD_STEP);
  localparam logic [15:0] GAP1      = 16'(WAVE_GAP);
  localparam logic [15:0] GAP2      = 16'(2 * WAVE_GAP);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] GAP_MOD   = 16'(BOARD_WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // Wave bitfield: all columns occupied except a three-column hole at g.
  function automatic logic [BOARD_WIDTH-1:0] gap_bf(input logic [15:0] rnd);
    logic [15:0]            g;
    logic [BOARD_WIDTH-1:0] hole;
    g    = rnd % GAP_MOD;
    hole = {{(BOARD_WIDTH-3){1'b0}}, 3'b111} << g;
    return ~hole;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                        state_q,    state_d;
  logic [31:0]                   cyc_q,      cyc_d;
  logic [15:0]                   step_cnt_q, step_d;
  logic [31:0]                   period_q,   period_d;
  logic [15:0]                   score_q,    score_d;
  logic [15:0]                   lfsr_q,     lfsr_d;
  logic [2:0][7:0]               y_q,        y_d;
  logic [2:0][BOARD_WIDTH-1:0]   bf_q,       bf_d;

  logic [BOARD_WIDTH-1:0]        fresh_bf;
  logic [1:0]                    wraps;
  logic [16:0]                   score_sum;
  logic                          lfsr_fb;

  // Fibonacci LFSR, taps 16,14,13,11. Free-running in every state so the
  // gap positions depend on when the player presses start.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    cyc_d     = cyc_q;
    step_d    = step_cnt_q;
    period_d  = period_q;
    score_d   = score_q;
    y_d       = y_q;
    bf_d      = bf_q;
    fresh_bf  = gap_bf(lfsr_q);
    wraps     = 2'd0;
    score_sum = 17'd0;

    unique case (state_q)
      IDLE, DEAD: begin
        if (start) begin
          state_d  = RUN;
          score_d  = 16'd0;
          period_d = BASE_P;
          cyc_d    = 32'd0;
          step_d   = 16'd0;
          y_d[0]   = TOP_Y;
          bf_d[0]  = fresh_bf;
          y_d[1]   = 8'd0;
          bf_d[1]  = '0;
          y_d[2]   = 8'd0;
          bf_d[2]  = '0;
        end
      end

      RUN: begin
        // Death wins over a coincident step: the board freezes as it was.
        if (death) begin
          state_d = DEAD;
        end else if (cyc_q == period_q - 32'd1) begin
          cyc_d = 32'd0;

          // Active waves (y != 0) descend; one on row 1 wraps to the top.
          for (int i = 0; i < 3; i++) begin
            if (y_q[i] == 8'd1) begin
              y_d[i]  = TOP_Y;
              bf_d[i] = fresh_bf;
              wraps   = wraps + 2'd1;
            end else if (y_q[i] != 8'd0) begin
              y_d[i] = y_q[i] - 8'd1;
            end
          end

          // Step counter only matters until both late waves are launched.
          if (step_cnt_q < GAP2) begin
            step_d = step_cnt_q + 16'd1;
            if (step_d == GAP1) begin
              y_d[1]  = TOP_Y;
              bf_d[1] = fresh_bf;
            end
            if (step_d == GAP2) begin
              y_d[2]  = TOP_Y;
              bf_d[2] = fresh_bf;
            end
          end

          score_sum = {1'b0, score_q} + {15'd0, wraps};
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];

          // Crossing a multiple of eight speeds the game up. The counter
          // restarts at 0 this cycle, so the new period governs the next count.
          if (score_d[15:3] != score_q[15:3]) begin
            period_d = (period_q >= MIN_P + STEP_P) ? (period_q - STEP_P) : MIN_P;
          end
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the wave row/bitfield arrays drive outputs directly and must read
      // as zero in reset, so unlike a storage memory they are reset here.
      state_q    <= IDLE;
      running    <= 1'b0;
      cyc_q      <= 32'd0;
      step_cnt_q <= 16'd0;
      period_q   <= BASE_P;
      score_q    <= 16'd0;
      lfsr_q     <= LFSR_SEED;
      y_q        <= '0;
      bf_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      running    <= (state_d == RUN);
      cyc_q      <= cyc_d;
      step_cnt_q <= step_d;
      period_q   <= period_d;
      score_q    <= score_d;
      lfsr_q     <= lfsr_d;
      y_q        <= y_d;
      bf_q       <= bf_d;
    end
  end

  assign wave0_y  = y_q[0];
  assign wave1_y  = y_q[1];
  assign wave2_y  = y_q[2];
  assign wave0_bf = bf_q[0];
  assign wave1_bf = bf_q[1];
  assign wave2_bf = bf_q[2];
  assign score    = score_q;

  // ---------------------------------------------------------------------------
  // Best score
  // ---------------------------------------------------------------------------
`ifdef HIGH_SCORE_EN
  logic [15:0] high_q;
  logic        dead_entry;

  // score_q is frozen on the death cycle, so it is the final game score.
  assign dead_entry = (state_q == RUN) && death;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_q <= 16'd0;
    end else if (dead_entry && (score_q > high_q)) begin
      high_q <= score_q;
    end
  end

  assign high_score = high_q;
`else
  assign high_score = 16'd0;
`endif

endmodule

// File: tb/tb_wave_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wave_scheduler
//
// Two instances share clk/rst/start: dut_a runs fast (period 4 -> 3 -> 2) for
// the wave/death/high-score scenarios, dut_b uses period 40/30/20 for the
// speed-up scenario. A game-level model of each instance is advanced on every
// rising edge and compared against the outputs on every falling edge; directed
// literal expectations pin both the model and the design.
// -----------------------------------------------------------------------------
module tb_wave_scheduler;

  localparam int TOP      = 18;
  localparam int GAP      = 6;
  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_DEAD  = 2;
`ifdef HIGH_SCORE_EN
  localparam int HS_EXP   = 5;
`else
  localparam int HS_EXP   = 0;
`endif

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic start   = 1'b0;
  logic death_a = 1'b0;
  logic death_b = 1'b0;
  logic cmp_en  = 1'b0;

  always #5 clk = ~clk;

  logic        run_a, run_b;
  logic [7:0]  a_y0, a_y1, a_y2, b_y0, b_y1, b_y2;
  logic [39:0] a_bf0, a_bf1, a_bf2, b_bf0, b_bf1, b_bf2;
  logic [15:0] a_score, a_hs, b_score, b_hs;

  wave_scheduler #(
    .BOARD_HEIGHT(20), .BOARD_WIDTH(40), .BASE_PERIOD(4),
    .MIN_PERIOD(2), .PERIOD_STEP(1), .WAVE_GAP(GAP)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .death(death_a), .running(run_a),
    .wave0_y(a_y0), .wave1_y(a_y1), .wave2_y(a_y2),
    .wave0_bf(a_bf0), .wave1_bf(a_bf1), .wave2_bf(a_bf2),
    .score(a_score), .high_score(a_hs)
  );

  wave_scheduler #(
    .BOARD_HEIGHT(20), .BOARD_WIDTH(40), .BASE_PERIOD(40),
    .MIN_PERIOD(20), .PERIOD_STEP(10), .WAVE_GAP(GAP)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .death(death_b), .running(run_b),
    .wave0_y(b_y0), .wave1_y(b_y1), .wave2_y(b_y2),
    .wave0_bf(b_bf0), .wave1_bf(b_bf1), .wave2_bf(b_bf2),
    .score(b_score), .high_score(b_hs)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    check(name, 128'(act), 128'(exp));
  endtask

  // 1 when the bitfield has exactly three clear bits and they are adjacent.
  function automatic int bf_shape(input logic [39:0] b);
    int zeros;
    int low;
    zeros = 0;
    low   = -1;
    for (int j = 0; j < 40; j++) begin
      if (!b[j]) begin
        zeros++;
        if (low < 0) low = j;
      end
    end
    if (zeros != 3 || low > 37) return 0;
    return (!b[low+1] && !b[low+2]) ? 1 : 0;
  endfunction

  // ---------------------------------------------------------------------------
  // Game model (index 0 = dut_a, 1 = dut_b)
  // ---------------------------------------------------------------------------
  int          m_state [2];
  int          m_cyc   [2];
  int          m_steps [2];
  int          m_period[2];
  int          m_score [2];
  int          m_hs    [2];
  int          m_y     [2][3];
  logic [39:0] m_bf    [2][3];
  logic [15:0] m_lfsr  [2];

  function automatic int base_of(input int d);
    return (d == 0) ? 4 : 40;
  endfunction
  function automatic int min_of(input int d);
    return (d == 0) ? 2 : 20;
  endfunction
  function automatic int dec_of(input int d);
    return (d == 0) ? 1 : 10;
  endfunction

  function automatic logic [39:0] fresh_bf(input logic [15:0] l);
    logic [39:0] b;
    int          g;
    b = {40{1'b1}};
    g = int'(l) % 38;
    for (int j = 0; j < 3; j++) b[g+j] = 1'b0;
    return b;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    logic [15:0] fb;
    fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'h0001;
    return (l >> 1) | (fb << 15);
  endfunction

  task automatic model_reset(input int d);
    m_state[d]  = ST_IDLE;
    m_cyc[d]    = 0;
    m_steps[d]  = 0;
    m_period[d] = base_of(d);
    m_score[d]  = 0;
    m_hs[d]     = 0;
    m_lfsr[d]   = 16'hACE1;
    for (int w = 0; w < 3; w++) begin
      m_y[d][w]  = 0;
      m_bf[d][w] = '0;
    end
  endtask

  task automatic model_tick(input int d, input logic s, input logic dth);
    logic [39:0] nb;
    int          old;
    nb        = fresh_bf(m_lfsr[d]);
    m_lfsr[d] = lfsr_adv(m_lfsr[d]);
    if (m_state[d] != ST_RUN) begin
      if (s) begin
        m_state[d]  = ST_RUN;
        m_score[d]  = 0;
        m_period[d] = base_of(d);
        m_cyc[d]    = 0;
        m_steps[d]  = 0;
        m_y[d][0]   = TOP;
        m_bf[d][0]  = nb;
        for (int w = 1; w < 3; w++) begin
          m_y[d][w]  = 0;
          m_bf[d][w] = '0;
        end
      end
    end else if (dth) begin
      m_state[d] = ST_DEAD;
`ifdef HIGH_SCORE_EN
      if (m_score[d] > m_hs[d]) m_hs[d] = m_score[d];
`endif
    end else if (m_cyc[d] + 1 < m_period[d]) begin
      m_cyc[d]++;
    end else begin
      m_cyc[d] = 0;
      old      = m_score[d];
      for (int w = 0; w < 3; w++) begin
        if (m_y[d][w] == 1) begin
          m_y[d][w]  = TOP;
          m_bf[d][w] = nb;
          if (m_score[d] < 65535) m_score[d]++;
        end else if (m_y[d][w] != 0) begin
          m_y[d][w]--;
        end
      end
      if (m_steps[d] < 2 * GAP) begin
        m_steps[d]++;
        if (m_steps[d] % GAP == 0) begin
          m_y[d][m_steps[d] / GAP]  = TOP;
          m_bf[d][m_steps[d] / GAP] = nb;
        end
      end
      if (m_score[d] / 8 != old / 8) begin
        m_period[d] = (m_period[d] - dec_of(d) < min_of(d)) ? min_of(d) : m_period[d] - dec_of(d);
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_tick(0, start, death_a);
      model_tick(1, start, death_b);
    end
  end

  task automatic compare_dut(input int d, input logic r, input logic [23:0] ys,
                             input logic [119:0] bfs, input logic [15:0] sc,
                             input logic [15:0] hs);
    string t;
    t = (d == 0) ? "a" : "b";
    check({t, ".running"}, 128'(r), 128'(m_state[d] == ST_RUN));
    check({t, ".wave_y"}, 128'(ys), 128'({8'(m_y[d][2]), 8'(m_y[d][1]), 8'(m_y[d][0])}));
    check({t, ".wave_bf"}, 128'(bfs), 128'({m_bf[d][2], m_bf[d][1], m_bf[d][0]}));
    check({t, ".score"}, 128'(sc), 128'(16'(m_score[d])));
    check({t, ".high_score"}, 128'(hs), 128'(16'(m_hs[d])));
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      compare_dut(0, run_a, {a_y2, a_y1, a_y0}, {a_bf2, a_bf1, a_bf0}, a_score, a_hs);
      compare_dut(1, run_b, {b_y2, b_y1, b_y0}, {b_bf2, b_bf1, b_bf0}, b_score, b_hs);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_score(input int d, input int target, input string name);
    for (int i = 0; i < 20000; i++) begin
      if (int'((d == 0) ? a_score : b_score) == target) break;
      @(negedge clk);
    end
    check_i(name, int'((d == 0) ? a_score : b_score), target);
  endtask

  // Cycles from now until dut_b's wave0 row next changes (one step period).
  task automatic measure_b(input int exp, input string name);
    logic [7:0] prev;
    int         n;
    prev = b_y0;
    n    = 0;
    do begin
      @(negedge clk);
      n++;
    end while (b_y0 == prev && n < 1000);
    check_i(name, n, exp);
  endtask

  task automatic kill_a();
    death_a = 1'b1;
    @(negedge clk);
    death_a = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [23:0] snap_y;
    int          snap_s;
    int          found;

    repeat (3) @(negedge clk);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset a.running", 128'(run_a), 128'(0));
    check("reset a.wave0_y", 128'(a_y0), 128'(0));
    check("reset a.wave0_bf", 128'(a_bf0), 128'(0));
    check("reset a.score", 128'(a_score), 128'(0));
    check("reset b.high_score", 128'(b_hs), 128'(0));

    // Start: running the next cycle, wave0 at the top with a 3-wide gap.
    pulse_start();
    check("start a.running", 128'(run_a), 128'(1));
    check("start b.running", 128'(run_b), 128'(1));
    check("start a.wave0_y", 128'(a_y0), 128'(18));
    check("start a.wave1 inactive", 128'({a_y1, a_bf1}), 128'(0));
    check_i("start a.wave0_bf shape", bf_shape(a_bf0), 1);
    check_i("start b.wave0_bf shape", bf_shape(b_bf0), 1);

    // Period 4: one row every 4 cycles.
    repeat (4) @(negedge clk);
    check("step1 a.wave0_y", 128'(a_y0), 128'(17));
    repeat (4) @(negedge clk);
    check("step2 a.wave0_y", 128'(a_y0), 128'(16));
    repeat (60) @(negedge clk);
    check("step17 a.wave0_y", 128'(a_y0), 128'(1));
    check("step17 a.score", 128'(a_score), 128'(0));
    repeat (4) @(negedge clk);
    check("wrap a.wave0_y", 128'(a_y0), 128'(18));
    check("wrap a.score", 128'(a_score), 128'(1));
    check("wrap a.wave1_y", 128'(a_y1), 128'(6));
    check("wrap a.wave2_y", 128'(a_y2), 128'(12));
    check_i("wrap a.wave0_bf shape", bf_shape(a_bf0), 1);

    // Speed-up on dut_b: 40 -> 30 -> 20 -> clamped 20.
    wait_score(1, 8, "b reaches score 8");
    check_i("model b period at 8", m_period[1], 30);
    measure_b(30, "b step interval after score 8");
    wait_score(1, 16, "b reaches score 16");
    check_i("model b period at 16", m_period[1], 20);
    measure_b(20, "b step interval after score 16");
    wait_score(1, 24, "b reaches score 24");
    measure_b(20, "b step interval after score 24");

    // Death on a step cycle of dut_a: no step applied.
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_state[0] == ST_RUN && m_cyc[0] == m_period[0] - 1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_i("a step cycle found", found, 1);
    snap_y = {8'(m_y[0][2]), 8'(m_y[0][1]), 8'(m_y[0][0])};
    snap_s = m_score[0];
    kill_a();
    check("death a.running", 128'(run_a), 128'(0));
    check("death a.wave_y frozen", 128'({a_y2, a_y1, a_y0}), 128'(snap_y));
    check_i("death a.score frozen", int'(a_score), snap_s);
    repeat (5) @(negedge clk);
    check("dead a.wave_y still frozen", 128'({a_y2, a_y1, a_y0}), 128'(snap_y));

    // Reset in the middle of dut_b's game: outputs clear without a clock.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset b.running", 128'(run_b), 128'(0));
    check("midreset b.wave_y", 128'({b_y2, b_y1, b_y0}), 128'(0));
    check("midreset b.wave_bf", 128'({b_bf2, b_bf1, b_bf0}), 128'(0));
    check("midreset b.score", 128'(b_score), 128'(0));
    check("midreset a.high_score", 128'(a_hs), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    check("restart b.running", 128'(run_b), 128'(1));
    check("restart b.score", 128'(b_score), 128'(0));
    check("restart b.wave0_y", 128'(b_y0), 128'(18));

    // Two games on dut_a scoring 5 then 3.
    wait_score(0, 5, "a game1 reaches 5");
    kill_a();
    check("game1 a.running", 128'(run_a), 128'(0));
    check_i("game1 a.high_score", int'(a_hs), HS_EXP);
    pulse_start();
    check("game2 a.score", 128'(a_score), 128'(0));
    check("game2 b.running", 128'(run_b), 128'(1));
    wait_score(0, 3, "a game2 reaches 3");
    kill_a();
    check_i("game2 a.high_score", int'(a_hs), HS_EXP);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
